uart_cmd_decoder: RTL and testbench

- Sits between the UART RX FIFO and the stopwatch display/counter block.
- Pops received bytes from the RX FIFO and decodes ASCII commands into single-cycle control pulses: run/stop, mode, clear. These drive the counter's uart_enable / uart_mode / uart_clear inputs.
- Optionally echoes each accepted byte, or a NAK character for unknown bytes, into the TX FIFO.
- Keeps a saturating count of unknown bytes for debug.

---
 rtl/uart_cmd_decoder_pkg.sv | 23 ++
 rtl/uart_cmd_decoder_if.sv | 27 ++
 rtl/uart_cmd_decoder_cmd_match.sv | 27 ++
 rtl/uart_cmd_decoder.sv | 122 ++++++++++++
 tb/tb_uart_cmd_decoder.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_decoder_pkg.sv
// uart_cmd_decoder_pkg: shared state encoding and ASCII constants for the UART command decoder
package uart_cmd_decoder_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LATCH,
        ST_DECODE,
        ST_ECHO
    } state_e;

    localparam byte_t ASCII_R   = 8'h72;
    localparam byte_t ASCII_M   = 8'h6D;
    localparam byte_t ASCII_C   = 8'h63;
    localparam byte_t ASCII_NAK = 8'h3F;
    localparam byte_t ASCII_CR  = 8'h0D;
    localparam byte_t ASCII_LF  = 8'h0A;
    // Flipping this bit maps a lower-case letter to its upper-case form.
    localparam byte_t CASE_BIT  = 8'h20;

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if: RX/TX FIFO handshake bundle between the decoder and the UART FIFOs
//   rx_empty/rx_data : RX FIFO status and read data (data valid one cycle after rx_pop)
//   rx_pop           : RX FIFO read strobe
//   tx_full          : TX FIFO full flag
//   tx_push/tx_data  : TX FIFO write strobe and data
//   master = decoder side, slave = FIFO side
interface uart_cmd_decoder_if;
    import uart_cmd_decoder_pkg::*;

    logic  rx_empty;
    byte_t rx_data;
    logic  rx_pop;
    logic  tx_full;
    logic  tx_push;
    byte_t tx_data;

    modport master (
        input  rx_empty, rx_data, tx_full,
        output rx_pop, tx_push, tx_data
    );

    modport slave (
        output rx_empty, rx_data, tx_full,
        input  rx_pop, tx_push, tx_data
    );

endinterface

// File: rtl/uart_cmd_decoder_cmd_match.sv
// uart_cmd_decoder_cmd_match: combinational classifier of one received byte
//   data       : byte under test
//   is_run/is_mode/is_clear : command match, either letter case
//   is_eol     : CR or LF, silently ignored
//   is_unknown : anything else
module uart_cmd_decoder_cmd_match
    import uart_cmd_decoder_pkg::*;
#(
    parameter byte_t CMD_RUN   = ASCII_R,
    parameter byte_t CMD_MODE  = ASCII_M,
    parameter byte_t CMD_CLEAR = ASCII_C
) (
    input  byte_t data,
    output logic  is_run,
    output logic  is_mode,
    output logic  is_clear,
    output logic  is_eol,
    output logic  is_unknown
);

    assign is_run     = (data == CMD_RUN)   || (data == (CMD_RUN ^ CASE_BIT));
    assign is_mode    = (data == CMD_MODE)  || (data == (CMD_MODE ^ CASE_BIT));
    assign is_clear   = (data == CMD_CLEAR) || (data == (CMD_CLEAR ^ CASE_BIT));
    assign is_eol     = (data == ASCII_CR)  || (data == ASCII_LF);
    assign is_unknown = !(is_run || is_mode || is_clear || is_eol);

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: pops RX bytes, decodes ASCII commands into one-cycle pulses, echoes/NAKs to TX
//   clk, rst  : system clock, asynchronous active-low reset
//   fifo      : RX/TX FIFO handshake (master side)
//   o_run, o_mode, o_clear : one-cycle command pulses
//   o_err_cnt : saturating count of unknown bytes
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter bit    ECHO_EN   = 1'b1,
    parameter byte_t CMD_RUN   = ASCII_R,
    parameter byte_t CMD_MODE  = ASCII_M,
    parameter byte_t CMD_CLEAR = ASCII_C,
    parameter byte_t NAK_CHAR  = ASCII_NAK
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_cmd_decoder_if.master         fifo,
    output logic                       o_run,
    output logic                       o_mode,
    output logic                       o_clear,
    output byte_t                      o_err_cnt
);

    state_e state_q, state_d;
    logic   rx_pop_q, rx_pop_d;
    logic   tx_push_q, tx_push_d;
    byte_t  tx_data_q, tx_data_d;
    logic   run_q, run_d;
    logic   mode_q, mode_d;
    logic   clear_q, clear_d;
    byte_t  err_q, err_d;
    byte_t  byte_q, byte_d;
    logic   nak_q, nak_d;
    logic   is_run, is_mode, is_clear, is_eol, is_unknown;

    uart_cmd_decoder_cmd_match #(
        .CMD_RUN   (CMD_RUN),
        .CMD_MODE  (CMD_MODE),
        .CMD_CLEAR (CMD_CLEAR)
    ) u_match (
        .data       (byte_q),
        .is_run     (is_run),
        .is_mode    (is_mode),
        .is_clear   (is_clear),
        .is_eol     (is_eol),
        .is_unknown (is_unknown)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rx_pop_q  <= 1'b0;
            tx_push_q <= 1'b0;
            tx_data_q <= 8'h00;
            run_q     <= 1'b0;
            mode_q    <= 1'b0;
            clear_q   <= 1'b0;
            err_q     <= 8'h00;
            byte_q    <= 8'h00;
            nak_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_pop_q  <= rx_pop_d;
            tx_push_q <= tx_push_d;
            tx_data_q <= tx_data_d;
            run_q     <= run_d;
            mode_q    <= mode_d;
            clear_q   <= clear_d;
            err_q     <= err_d;
            byte_q    <= byte_d;
            nak_q     <= nak_d;
        end
    end

    // All strobes are registered, so each is high during the cycle after the decision.
    always_comb begin
        state_d   = state_q;
        rx_pop_d  = 1'b0;
        tx_push_d = 1'b0;
        tx_data_d = tx_data_q;
        run_d     = 1'b0;
        mode_d    = 1'b0;
        clear_d   = 1'b0;
        err_d     = err_q;
        byte_d    = byte_q;
        nak_d     = nak_q;
        case (state_q)
            ST_IDLE: begin
                rx_pop_d = !fifo.rx_empty;
                state_d  = fifo.rx_empty ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT:  state_d = ST_LATCH;
            ST_LATCH: begin
                byte_d  = fifo.rx_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                run_d   = is_run;
                mode_d  = is_mode;
                clear_d = is_clear;
                nak_d   = is_unknown;
                err_d   = (is_unknown && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
                state_d = (ECHO_EN && !is_eol) ? ST_ECHO : ST_IDLE;
            end
            ST_ECHO: begin
                tx_push_d = !fifo.tx_full;
                tx_data_d = fifo.tx_full ? tx_data_q : (nak_q ? NAK_CHAR : byte_q);
                state_d   = fifo.tx_full ? ST_ECHO : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fifo.rx_pop  = rx_pop_q;
    assign fifo.tx_push = tx_push_q;
    assign fifo.tx_data = tx_data_q;
    assign o_run        = run_q;
    assign o_mode       = mode_q;
    assign o_clear      = clear_q;
    assign o_err_cnt    = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed self-checking bench with RX/TX FIFO models around uart_cmd_decoder
module tb_uart_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       o_run, o_mode, o_clear;
    logic [7:0] o_err_cnt;

    uart_cmd_decoder_if bus();

    uart_cmd_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .fifo      (bus),
        .o_run     (o_run),
        .o_mode    (o_mode),
        .o_clear   (o_clear),
        .o_err_cnt (o_err_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    int n_pop = 0, n_run = 0, n_mode = 0, n_clear = 0, n_viol = 0;
    int cyc = 0, mode_cyc = 0, clear_cyc = 0;
    int total = 0, passed = 0;

    // FIFO models plus protocol monitor; everything sampled at the active edge.
    always @(posedge clk) begin
        cyc++;
        if (bus.rx_pop) begin
            if (bus.rx_empty || rxq.size() == 0) n_viol++;
            else begin
                bus.rx_data <= rxq.pop_front();
                n_pop++;
            end
        end
        if (bus.tx_push) begin
            if (bus.tx_full) n_viol++;
            txq.push_back(bus.tx_data);
        end
        if (int'(o_run) + int'(o_mode) + int'(o_clear) > 1) n_viol++;
        if (o_run) n_run++;
        if (o_mode) begin n_mode++; mode_cyc = cyc; end
        if (o_clear) begin n_clear++; clear_cyc = cyc; end
        bus.rx_empty <= (rxq.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.tx_full = 1'b0;
        tick(3);
        chk("rst_rx_pop", bus.rx_pop, 0);
        chk("rst_tx_push", bus.tx_push, 0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_pulses", {o_run, o_mode, o_clear}, 3'b000);
        chk("rst_err", o_err_cnt, 0);
        rst = 1'b1;
        tick(2);

        // 'r': exact pipeline timing
        rxq.push_back(8'h72);
        tick(1);
        chk("r_pop_early", bus.rx_pop, 0);
        tick(1);
        chk("r_pop", bus.rx_pop, 1);
        tick(1);
        chk("r_pop_once", bus.rx_pop, 0);
        tick(2);
        chk("r_run_pulse", o_run, 1);
        tick(1);
        chk("r_run_width", o_run, 0);
        chk("r_echo_push", bus.tx_push, 1);
        chk("r_echo_data", bus.tx_data, 8'h72);
        tick(1);
        chk("r_push_width", bus.tx_push, 0);
        chk("r_run_count", n_run, 1);
        txq.delete();

        // 'M','C' back to back: one byte per 5 cycles with echo
        rxq.push_back(8'h4D);
        rxq.push_back(8'h43);
        tick(20);
        chk("mc_mode_count", n_mode, 1);
        chk("mc_clear_count", n_clear, 1);
        chk("mc_spacing", clear_cyc - mode_cyc, 5);
        chk("mc_echo_count", txq.size(), 2);
        chk("mc_echo0", txq[0], 8'h4D);
        chk("mc_echo1", txq[1], 8'h43);
        chk("mc_err", o_err_cnt, 0);
        txq.delete();

        // 'x': unknown byte, NAK echoed
        rxq.push_back(8'h78);
        tick(12);
        chk("x_no_pulse", n_run + n_mode + n_clear, 3);
        chk("x_err", o_err_cnt, 1);
        chk("x_nak_count", txq.size(), 1);
        chk("x_nak_data", txq[0], 8'h3F);
        txq.delete();

        // TX backpressure: 'r' then 'm' pending while tx_full held
        bus.tx_full = 1'b1;
        rxq.push_back(8'h72);
        rxq.push_back(8'h6D);
        tick(50);
        chk("bp_run_once", n_run, 2);
        chk("bp_no_push", txq.size(), 0);
        chk("bp_one_pop", n_pop, 5);
        chk("bp_mode_held", n_mode, 1);
        bus.tx_full = 1'b0;
        tick(20);
        chk("bp_pops_after", n_pop, 6);
        chk("bp_mode_after", n_mode, 2);
        chk("bp_echo_count", txq.size(), 2);
        chk("bp_echo0", txq[0], 8'h72);
        chk("bp_echo1", txq[1], 8'h6D);
        txq.delete();

        // CR/LF: popped silently
        rxq.push_back(8'h0D);
        rxq.push_back(8'h0A);
        tick(20);
        chk("eol_pops", n_pop, 8);
        chk("eol_no_pulse", n_run + n_mode + n_clear, 5);
        chk("eol_no_push", txq.size(), 0);
        chk("eol_err", o_err_cnt, 1);

        // 300 unknown bytes: counter saturates
        for (int i = 0; i < 300; i++) rxq.push_back(8'h7A);
        tick(1600);
        chk("sat_pops", n_pop, 308);
        chk("sat_err", o_err_cnt, 8'hFF);
        chk("sat_nak_count", txq.size(), 300);
        txq.delete();

        // Reset while 'c' sits in DECODE
        rxq.push_back(8'h63);
        tick(4);
        rst = 1'b0;
        #1;
        chk("mid_rst_outs", {bus.rx_pop, bus.tx_push, o_run, o_mode, o_clear}, 5'b0);
        chk("mid_rst_data", bus.tx_data, 8'h00);
        chk("mid_rst_err", o_err_cnt, 0);
        tick(2);
        rst = 1'b1;
        tick(10);
        chk("mid_rst_no_clear", n_clear, 1);
        chk("mid_rst_no_echo", txq.size(), 0);
        rxq.push_back(8'h43);
        tick(12);
        chk("post_rst_clear", n_clear, 2);
        chk("post_rst_echo_count", txq.size(), 1);
        chk("post_rst_echo", txq[0], 8'h43);
        chk("protocol_violations", n_viol, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
